// File: rtl/ins_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// State encodings are plain 2-bit constants for legacy netlist compatibility.
package ins_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t OWN  = 2'd1;
  localparam arb_state_t GAP  = 2'd2;
  localparam arb_state_t BOOT = 2'd3;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ins_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
// Returns a one-hot grant, its index and an any-request flag.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] ci;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    ci  = '0;
    for (int k = 0; k < N; k++) begin
      ci = IW'((int'(ptr) + k) % N);
      if (!any && req[ci]) begin
        any     = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/ins_mem_arbiter.sv
// N-channel round-robin arbiter for a single-port instruction memory.
// Define ARB_WRITE_PROTECT_EN to allow writes from channel 0 only.
module ins_mem_arbiter
  import ins_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int N_CH       = 2,
  parameter int MAX_BURST  = 16,
  parameter int SWITCH_GAP = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     boot_mode,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH-1:0]          we,
  input  logic [N_CH*ADDR_W-1:0]   addr,
  input  logic [N_CH*DATA_W-1:0]   wdata,
  output logic [N_CH-1:0]          gnt,
  output logic [N_CH-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [N_CH-1:0]          wr_err,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int IW = ch_idx_w(N_CH);
  localparam logic [2:0] GAP_LAST =
    3'((SWITCH_GAP > 0) ? SWITCH_GAP - 1 : 0);

  arb_state_t    state, state_n;
  logic [IW-1:0] owner, owner_n;
  logic [IW-1:0] rr_ptr, rr_ptr_n, nxt_ptr;
  logic [31:0]   burst_cnt, burst_n, bc_inc;
  logic [2:0]    gap_cnt, gap_n;
  logic [N_CH-1:0] gnt_n, rvalid_n, wr_err_n;
  logic [N_CH-1:0] own_oh, pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          acc, wp, other_req, limit_hit;
  logic          do_arb, do_exit;

  rr_pick #(.N(N_CH), .IW(IW)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign own_oh = N_CH'(1) << owner;
  assign acc    = req[owner] & gnt[owner];

`ifdef ARB_WRITE_PROTECT_EN
  assign wp = acc & we[owner] & (owner != '0);
`else
  assign wp = 1'b0;
`endif

  assign mem_en    = acc & ~wp;
  assign mem_we    = we[owner] & mem_en;
  assign mem_addr  = (|gnt) ? addr[int'(owner)*ADDR_W +: ADDR_W] : '0;
  assign mem_wdata = (|gnt) ? wdata[int'(owner)*DATA_W +: DATA_W] : '0;
  assign rdata     = mem_rdata;

  assign other_req = |(req & ~own_oh);
  assign nxt_ptr   = (owner == IW'(N_CH - 1)) ? '0 : owner + 1'b1;
  assign bc_inc    = burst_cnt + 32'(acc);
  assign limit_hit = (MAX_BURST != 0) && other_req &&
                     (bc_inc >= 32'(MAX_BURST));

  assign rvalid_n = (acc & ~we[owner]) ? own_oh : '0;
  assign wr_err_n = wp ? own_oh : '0;

  // The final GAP cycle arbitrates itself so the dead time is SWITCH_GAP.
  always_comb begin
    state_n  = state;
    owner_n  = owner;
    rr_ptr_n = rr_ptr;
    burst_n  = burst_cnt;
    gap_n    = gap_cnt;
    gnt_n    = '0;
    do_arb   = 1'b0;
    do_exit  = 1'b0;
    unique case (state)
      IDLE: do_arb = 1'b1;
      OWN: begin
        gnt_n = own_oh;
        if ((MAX_BURST != 0) && (bc_inc > 32'(MAX_BURST)))
          burst_n = 32'(MAX_BURST);
        else
          burst_n = bc_inc;
        if (!req[owner] || limit_hit || boot_mode)
          do_exit = 1'b1;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) do_arb = 1'b1;
        else gap_n = gap_cnt + 3'd1;
      end
      BOOT: begin
        gnt_n = own_oh;
        if (!boot_mode) do_exit = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (do_exit) begin
      rr_ptr_n = nxt_ptr;
      burst_n  = '0;
      gap_n    = '0;
      gnt_n    = '0;
      state_n  = (SWITCH_GAP == 0) ? IDLE : GAP;
    end
    if (do_arb) begin
      gap_n   = '0;
      state_n = IDLE;
      if (boot_mode) begin
        state_n = BOOT;
        owner_n = '0;
        gnt_n   = N_CH'(1);
      end else if (pick_any) begin
        state_n = OWN;
        owner_n = pick_idx;
        gnt_n   = pick_gnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
      gnt       <= '0;
      rvalid    <= '0;
      wr_err    <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_n;
      gap_cnt   <= gap_n;
      gnt       <= gnt_n;
      rvalid    <= rvalid_n;
      wr_err    <= wr_err_n;
    end
  end

endmodule

// File: tb/tb_ins_mem_arbiter.sv
// Directed bench for ins_mem_arbiter: 2-channel and 4-channel instances.
// Write-protect expectations follow ARB_WRITE_PROTECT_EN.
module tb_ins_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        boot_mode;
  logic [1:0]  req, we, gnt, rvalid, wr_err;
  logic [63:0] addr, wdata;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;

  logic        boot4;
  logic [3:0]  req4, we4, gnt4, rvalid4, wr_err4;
  logic [127:0] addr4, wdata4;
  logic [31:0] rdata4, maddr4, mwd4, mrd4;
  logic        men4, mwe4;

  int npass = 0;
  int ntot  = 0;

`ifdef ARB_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  ins_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .N_CH(2),
    .MAX_BURST(4), .SWITCH_GAP(1)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .boot_mode(boot_mode),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .wr_err(wr_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  ins_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .N_CH(4),
    .MAX_BURST(16), .SWITCH_GAP(2)
  ) u4 (
    .clk(clk), .rst_n(rst_n), .boot_mode(boot4),
    .req(req4), .we(we4), .addr(addr4), .wdata(wdata4),
    .gnt(gnt4), .rvalid(rvalid4), .rdata(rdata4), .wr_err(wr_err4),
    .mem_en(men4), .mem_we(mwe4), .mem_addr(maddr4),
    .mem_wdata(mwd4), .mem_rdata(mrd4)
  );

  assign mrd4 = '0;

  // Memory model: read data is a fixed pattern of the address
  always @(posedge clk)
    if (mem_en && !mem_we) mem_rdata <= 32'hD000_0000 ^ mem_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; boot_mode = 1'b0; boot4 = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    req4 = '0; we4 = '0; addr4 = '0; wdata4 = '0;
    tick(); tick(); #2;
    ntot++; if (gnt !== 2'b00) $display("FAIL reset_gnt got %b want 00", gnt); else npass++;
    ntot++; if (rvalid !== 2'b00) $display("FAIL reset_rvalid got %b want 00", rvalid); else npass++;
    ntot++; if (wr_err !== 2'b00) $display("FAIL reset_wr_err got %b want 00", wr_err); else npass++;
    ntot++; if ({mem_en, mem_we} !== 2'b00) $display("FAIL reset_mem got %b want 00", {mem_en, mem_we}); else npass++;
    ntot++; if (gnt4 !== 4'b0000) $display("FAIL reset_gnt4 got %b want 0000", gnt4); else npass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    req = 2'b10; we = 2'b00; addr = {32'h40, 32'h0};
    #2;
    ntot++; if (gnt !== 2'b00) $display("FAIL rd_t0_gnt got %b want 00", gnt); else npass++;
    tick(); #2;
    ntot++; if (gnt !== 2'b10) $display("FAIL rd_t1_gnt got %b want 10", gnt); else npass++;
    ntot++; if ({mem_en, mem_we} !== 2'b10) $display("FAIL rd_t1_en got %b want 10", {mem_en, mem_we}); else npass++;
    ntot++; if (mem_addr !== 32'h40) $display("FAIL rd_t1_addr got %h want 00000040", mem_addr); else npass++;
    tick(); req = 2'b00; #2;
    ntot++; if (rvalid !== 2'b10) $display("FAIL rd_t2_rvalid got %b want 10", rvalid); else npass++;
    ntot++; if (rdata !== 32'hD000_0040) $display("FAIL rd_t2_rdata got %h want d0000040", rdata); else npass++;
    tick(); #2;
    ntot++; if ({gnt, rvalid} !== 4'b0000) $display("FAIL rd_t3_idle got %b want 0000", {gnt, rvalid}); else npass++;
    tick();
  endtask

  task automatic test_burst();
    logic [1:0] eg [14] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                            2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
                            2'b01, 2'b01, 2'b01, 2'b01};
    logic [1:0] erv;
    logic [31:0] ea;
    addr = {32'h200, 32'h100}; we = 2'b00; req = 2'b11;
    for (int i = 0; i < 14; i++) begin
      tick(); #2;
      erv = (i == 0) ? 2'b00 : eg[i-1];
      ea  = eg[i][1] ? 32'h200 : 32'h100;
      ntot++; if (gnt !== eg[i]) $display("FAIL burst_gnt[%0d] got %b want %b", i, gnt, eg[i]); else npass++;
      ntot++; if (mem_en !== (|eg[i])) $display("FAIL burst_en[%0d] got %b want %b", i, mem_en, |eg[i]); else npass++;
      ntot++; if (rvalid !== erv) $display("FAIL burst_rvalid[%0d] got %b want %b", i, rvalid, erv); else npass++;
      if (|eg[i]) begin
        ntot++; if (mem_addr !== ea) $display("FAIL burst_addr[%0d] got %h want %h", i, mem_addr, ea); else npass++;
      end
    end
    tick(); req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_boot();
    req = 2'b10; we = 2'b00; addr = {32'h300, 32'h0};
    tick(); #2;
    ntot++; if (gnt !== 2'b10) $display("FAIL boot_own1 got %b want 10", gnt); else npass++;
    tick(); boot_mode = 1'b1; #2;
    ntot++; if ({gnt, mem_en} !== 3'b101) $display("FAIL boot_last_acc got %b want 101", {gnt, mem_en}); else npass++;
    tick(); #2;
    ntot++; if ({gnt, mem_en} !== 3'b000) $display("FAIL boot_gap got %b want 000", {gnt, mem_en}); else npass++;
    ntot++; if (rvalid !== 2'b10) $display("FAIL boot_rvalid got %b want 10", rvalid); else npass++;
    for (int k = 0; k < 3; k++) begin
      tick(); #2;
      ntot++; if ({gnt, mem_en} !== 3'b010) $display("FAIL boot_hold[%0d] got %b want 010", k, {gnt, mem_en}); else npass++;
    end
    tick(); boot_mode = 1'b0; #2;
    ntot++; if (gnt !== 2'b01) $display("FAIL boot_exit got %b want 01", gnt); else npass++;
    tick(); #2;
    ntot++; if (gnt !== 2'b00) $display("FAIL boot_exit_gap got %b want 00", gnt); else npass++;
    tick(); #2;
    ntot++; if (gnt !== 2'b10) $display("FAIL boot_next_owner got %b want 10", gnt); else npass++;
    tick(); req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_write_protect();
    logic [1:0] e_err;
    e_err = WP ? 2'b10 : 2'b00;
    req = 2'b10; we = 2'b10;
    addr = {32'h10, 32'h0}; wdata = {32'hCAFE_0001, 32'h0};
    tick(); #2;
    ntot++; if (gnt !== 2'b10) $display("FAIL wp_ch1_gnt got %b want 10", gnt); else npass++;
    ntot++; if ({mem_en, mem_we} !== {!WP, !WP}) $display("FAIL wp_ch1_mem got %b want %b", {mem_en, mem_we}, {!WP, !WP}); else npass++;
    tick(); req = 2'b00; we = 2'b00; #2;
    ntot++; if (wr_err !== e_err) $display("FAIL wp_ch1_err got %b want %b", wr_err, e_err); else npass++;
    ntot++; if (rvalid !== 2'b00) $display("FAIL wp_ch1_rvalid got %b want 00", rvalid); else npass++;
    tick(); tick();
    req = 2'b01; we = 2'b01;
    addr = {32'h0, 32'h10}; wdata = {32'h0, 32'hCAFE_0000};
    tick(); #2;
    ntot++; if ({mem_en, mem_we} !== 2'b11) $display("FAIL wp_ch0_mem got %b want 11", {mem_en, mem_we}); else npass++;
    ntot++; if (mem_addr !== 32'h10) $display("FAIL wp_ch0_addr got %h want 00000010", mem_addr); else npass++;
    ntot++; if (mem_wdata !== 32'hCAFE_0000) $display("FAIL wp_ch0_wdata got %h want cafe0000", mem_wdata); else npass++;
    tick(); req = 2'b00; we = 2'b00; #2;
    ntot++; if (wr_err !== 2'b00) $display("FAIL wp_ch0_err got %b want 00", wr_err); else npass++;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    req = 2'b10; we = 2'b00; addr = {32'h44, 32'h0};
    tick(); #2;
    ntot++; if (mem_en !== 1'b1) $display("FAIL rmid_pre_en got %b want 1", mem_en); else npass++;
    rst_n = 1'b0; #1;
    ntot++; if ({gnt, rvalid, mem_en} !== 5'b0) $display("FAIL rmid_async got %b want 00000", {gnt, rvalid, mem_en}); else npass++;
    tick(); #2;
    ntot++; if (rvalid !== 2'b00) $display("FAIL rmid_rvalid got %b want 00", rvalid); else npass++;
    rst_n = 1'b1; req = 2'b11; addr = {32'h44, 32'h88};
    tick(); #2;
    ntot++; if (gnt !== 2'b01) $display("FAIL rmid_tie got %b want 01", gnt); else npass++;
    ntot++; if (mem_addr !== 32'h88) $display("FAIL rmid_addr got %h want 00000088", mem_addr); else npass++;
    tick(); req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_four_ch();
    req4 = 4'b0010;
    tick(); #2;
    ntot++; if (gnt4 !== 4'b0010) $display("FAIL rr4_ch1 got %b want 0010", gnt4); else npass++;
    tick(); req4 = 4'b0000;
    tick(); req4 = 4'b1010; #2;
    ntot++; if (gnt4 !== 4'b0000) $display("FAIL rr4_gap0 got %b want 0000", gnt4); else npass++;
    tick(); #2;
    ntot++; if (gnt4 !== 4'b0000) $display("FAIL rr4_gap1 got %b want 0000", gnt4); else npass++;
    tick(); #2;
    ntot++; if ({gnt4, men4} !== 5'b10001) $display("FAIL rr4_ch3 got %b want 10001", {gnt4, men4}); else npass++;
    tick(); req4 = 4'b0010; #2;
    ntot++; if (men4 !== 1'b0) $display("FAIL rr4_rel_en got %b want 0", men4); else npass++;
    tick(); tick(); tick(); #2;
    ntot++; if (gnt4 !== 4'b0010) $display("FAIL rr4_next_ch1 got %b want 0010", gnt4); else npass++;
    tick(); req4 = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst();
    test_boot();
    test_write_protect();
    test_reset_mid();
    test_four_ch();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
